// File: rtl/mux8_arbiter_if.sv
// Bus between the eight requesters and the shared 8-to-1 selector arbiter.
// Debug signals expose the arbiter's internal state so checkers can bind to them.
interface mux8_arbiter_if;
  // Handshake: requester k holds req[k] high for as long as it wants the path.
  // It owns the path in every cycle where gnt[k] is high. Dropping req[k] takes
  // effect at the next rising edge, so the requester sees one more grant cycle.
  // gnt is registered and is always zero or one-hot.
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       dout;
  logic       dbg_state;
  logic [7:0] dbg_hold_cnt;
  logic [2:0] dbg_ptr;

  // Arbiter side.
  modport slave (
    input  req, din,
    output gnt, sel, busy, dout, dbg_state, dbg_hold_cnt, dbg_ptr
  );

  // Requester / environment side.
  modport master (
    output req, din,
    input  gnt, sel, busy, dout, dbg_state, dbg_hold_cnt, dbg_ptr
  );
endinterface

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter for a shared 8-to-1 single-bit selector. It grants one
// requester at a time, limits each award to MAX_HOLD cycles, and registers
// the selected data bit.
module mux8_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  mux8_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

  logic [0:0] r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_gnt;
  logic [2:0] r_sel;
  logic       r_busy;
  logic       r_dout;

  logic       w_release;
  logic [2:0] w_scan_base;
  logic [3:0] w_pick;

  // Returns {found, index} for the first set request at base, base+1, ... mod 8.
  // The loop runs from the farthest offset down, so the nearest one wins.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Release decision and scan start. On release, the scan starts one past the
  // current grant. From IDLE, it starts at the unchanged pointer.
  always_comb begin
    w_release   = 1'b0;
    w_scan_base = r_ptr;
    if (r_state == ST_GRANT) begin
      w_release   = !bus.req[r_sel] || (r_hold_cnt == LP_MAX_HOLD);
      w_scan_base = r_sel + 3'd1;
    end
    w_pick = pick(bus.req, w_scan_base);
  end

  // Arbitration state machine, grant/select registers and registered data output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 3'd0;
      r_hold_cnt <= 8'd0;
      r_gnt      <= 8'd0;
      r_sel      <= 3'd0;
      r_busy     <= 1'b0;
      r_dout     <= 1'b0;
    end else begin
      r_dout <= (r_state == ST_GRANT) ? bus.din[r_sel] : 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick[3]) begin
            r_state    <= ST_GRANT;
            r_sel      <= w_pick[2:0];
            r_gnt      <= 8'b1 << w_pick[2:0];
            r_busy     <= 1'b1;
            r_hold_cnt <= 8'd1;
          end
        end
        default: begin
          if (w_release) begin
            r_ptr <= w_scan_base;
            if (w_pick[3]) begin
              // Back-to-back award, with no idle cycle. This may re-grant the same requester.
              r_sel      <= w_pick[2:0];
              r_gnt      <= 8'b1 << w_pick[2:0];
              r_hold_cnt <= 8'd1;
            end else begin
              // Nobody is waiting. sel keeps the index of the last grant.
              r_state    <= ST_IDLE;
              r_gnt      <= 8'd0;
              r_busy     <= 1'b0;
              r_hold_cnt <= 8'd0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.sel          = r_sel;
  assign bus.busy         = r_busy;
  assign bus.dout         = r_dout;
  assign bus.dbg_state    = r_state[0];
  assign bus.dbg_hold_cnt = r_hold_cnt;
  assign bus.dbg_ptr      = r_ptr;

endmodule
